// File: rtl/fifo_pkg.sv
// Shared constants and state type for the FIFO read-side drainer.
package fifo_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/fifo_rd_drainer_if.sv
// FIFO read port plus valid/ready output stream, as seen by the drainer (master).
interface fifo_rd_drainer_if #(
    parameter int unsigned DATA_W = fifo_pkg::DATA_W
);

    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data_out;
    logic              fifo_rd;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_data_out,
        input  m_ready,
        output fifo_rd,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_data_out,
        output m_ready,
        input  fifo_rd,
        input  m_valid,
        input  m_data
    );

endinterface

// File: rtl/fifo_skid_buf.sv
// Small circular buffer: push at tail, pop at head, occupancy and registered head data.
module fifo_skid_buf #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 2,
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned OW    = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [OW-1:0]     o_occ,
    output logic [DATA_W-1:0] o_head
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_head_ptr;
    logic [PW-1:0]     r_tail_ptr;
    logic [OW-1:0]     r_occ;
    logic              w_pop;

    assign w_pop  = i_pop && (r_occ != '0);
    assign o_occ  = r_occ;
    assign o_head = r_mem[r_head_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_head_ptr <= '0;
            r_tail_ptr <= '0;
            r_occ      <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_tail_ptr] <= i_push_data;
                r_tail_ptr        <= (r_tail_ptr == PW'(DEPTH - 1)) ? '0 : r_tail_ptr + PW'(1);
            end
            if (w_pop) begin
                r_head_ptr <= (r_head_ptr == PW'(DEPTH - 1)) ? '0 : r_head_ptr + PW'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Upstream credit must keep this from ever overflowing.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_push |-> (r_occ < OW'(DEPTH)) || w_pop);

endmodule

// File: rtl/fifo_rd_drainer.sv
// Drains a registered-read FIFO into a valid/ready stream with credit-based read issue.
module fifo_rd_drainer #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned BUF_DEPTH    = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    fifo_rd_drainer_if.master  bus,
    output logic               o_busy,
    output logic [CNT_W-1:0]   o_byte_cnt
);

    import fifo_pkg::*;

    localparam int unsigned OW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SW = $clog2(BUF_DEPTH + READ_LATENCY + 1);

    state_e                  r_state;
    logic [READ_LATENCY-1:0] r_pipe;
    logic [CNT_W-1:0]        r_byte_cnt;

    logic [OW-1:0]     w_occ;
    logic [DATA_W-1:0] w_head;
    logic [SW-1:0]     w_inflight;
    logic [SW-1:0]     w_need;
    logic              w_pop;
    logic              w_push;
    logic              w_fifo_rd;
    logic              w_m_valid;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < int'(READ_LATENCY); i++) begin
            w_inflight = w_inflight + SW'(r_pipe[i]);
        end
    end

    assign w_m_valid = (w_occ != '0);
    assign w_pop     = w_m_valid && bus.m_ready;
    assign w_push    = r_pipe[READ_LATENCY-1];
    // Room left once this cycle's pop and all outstanding reads have settled.
    assign w_need    = SW'(w_occ) + w_inflight - SW'(w_pop);
    assign w_fifo_rd = (r_state == RUN) && !bus.fifo_empty && (w_need < SW'(BUF_DEPTH));

    assign bus.fifo_rd = w_fifo_rd;
    assign bus.m_valid = w_m_valid;
    assign bus.m_data  = w_head;
    assign o_busy      = (r_state != IDLE);
    assign o_byte_cnt  = r_byte_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= w_fifo_rd;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (i_en) r_state <= RUN;
                RUN:     if (!i_en) r_state <= DRAIN;
                DRAIN: begin
                    if (i_en) begin
                        r_state <= RUN;
                    end else if ((w_inflight == '0) && (w_occ == '0)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_cnt <= '0;
        end else if (w_pop) begin
            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
        end
    end

    fifo_skid_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_skid_buf (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_push_data (bus.fifo_data_out),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_head      (w_head)
    );

    a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        bus.fifo_rd |-> !bus.fifo_empty);

endmodule

// File: doc/fifo_rd_drainer.md
Name: fifo_rd_drainer

Overview:
- Read-side stage that sits directly downstream of the 8-bit synchronous FIFO driven through the fifo interface (data_in/wr/rd/empty/full/fifo_cnt/data_out).
- Issues rd pulses only when the FIFO is non-empty and it has buffer room, and absorbs the FIFO's registered read latency.
- Re-presents the bytes on a valid/ready stream through a small skid buffer, so a stalling consumer never causes a lost or duplicated byte.
- Provides enable/drain control and a delivered-byte counter.

Parameters:
- DATA_W, 8, width of the FIFO data_out and stream data.
- READ_LATENCY, 1, cycles from a sampled rd to valid data_out.
- BUF_DEPTH, 2, skid-buffer entries; must be at least READ_LATENCY+1.
- CNT_W, 16, width of the delivered-byte counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- en  in  1  allows new FIFO reads while high.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data_out  in  DATA_W  FIFO read data.
- fifo_rd  out  1  FIFO read strobe.
- m_valid  out  1  stream data valid.
- m_ready  in  1  consumer ready.
- m_data  out  DATA_W  stream data.
- busy  out  1  high whenever state is not IDLE.
- byte_cnt  out  CNT_W  bytes delivered, i.e. handshakes with m_valid&&m_ready.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. rst is active-low and asynchronous.
- Reset values: fifo_rd=0, m_valid=0, m_data=0, busy=0, byte_cnt=0. Buffer pointers, inflight pipe and state are cleared.
- Reset mid-operation: in-flight reads and buffered bytes are discarded. No fifo_rd is issued until rst is released and en is sampled high.
- Inflight tracking:
  - A READ_LATENCY-deep shift register records issued reads.
  - When a tag exits the shift register, fifo_data_out is written into the buffer in that cycle.
- Read credit:
  - fifo_rd = (state==RUN) && !fifo_empty && (occ - pop + inflight) < BUF_DEPTH.
  - occ is the buffer occupancy; pop = m_valid && m_ready; inflight is the number of tags in the pipe.
  - The block never asserts fifo_rd while fifo_empty=1 (no underflow).
- Stream output:
  - m_valid = (occ != 0); m_data = buffer head, driven from registers.
  - m_data stays stable while m_valid && !m_ready.
- Buffer:
  - Circular, with head and tail pointers that wrap modulo BUF_DEPTH.
  - A simultaneous push and pop leaves occ unchanged.
  - A push into a full buffer cannot happen, guaranteed by the credit rule; the verification assertion is push -> occ<BUF_DEPTH || pop.
- Latency and throughput:
  - First byte: fifo_rd in cycle 0 gives m_valid in cycle READ_LATENCY+1, which is cycle 2 at defaults.
  - With m_ready held high and the FIFO non-empty, sustained throughput is 1 byte per cycle.
- State machine:
  - IDLE -> RUN when en=1.
  - RUN -> DRAIN when en=0.
  - DRAIN issues no new reads and completes in-flight reads and buffered bytes. DRAIN -> IDLE when inflight==0 && occ==0.
  - DRAIN -> RUN if en returns to 1.
  - IDLE with en=0 stays IDLE.
- byte_cnt increments on each handshake and wraps modulo 2^CNT_W without saturating.

Decomposition:
- Shared package fifo_pkg holds DATA_W, the FIFO depth constant (8) and the state typedef state_e {IDLE, RUN, DRAIN}.
- One sub-module, fifo_skid_buf: BUF_DEPTH-entry circular buffer with push/pop/occ/head outputs.
- Credit logic, the inflight pipe, the FSM and the counter live in fifo_rd_drainer.

Test Plan:
- Preload 0x11,0x22,0x33; en=1; m_ready=1 -> fifo_rd high cycles 0-2; m_data 0x11,0x22,0x33 on cycles 2-4; byte_cnt=3; fifo_rd never high while fifo_empty=1.
- Preload 8 bytes 0xA0..0xA7; m_ready=0 for 10 cycles, then 1 -> exactly 2 reads issued during the stall; m_data held at 0xA0; all 8 bytes are then delivered in order with no duplicates.
- Random m_ready at 50% over 200 bytes -> output sequence equals the input sequence; byte_cnt=200; occ never exceeds 2.
- en drops while 1 read is inflight and 1 byte is buffered -> state DRAIN, no further fifo_rd, both bytes delivered, then busy=0 and state IDLE.
- rst asserted asynchronously mid-stream with 2 bytes buffered -> m_valid=0, fifo_rd=0 and byte_cnt=0 immediately, without waiting for a clk edge; restart delivers the next FIFO byte correctly.
- Force byte_cnt to 16'hFFFF, complete 1 handshake -> byte_cnt=16'h0000.
